// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit holding HI/LO (optional MADD/MADDU via MDU_MADD_EN)
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   pend_q, pend_d;
    logic          pend_we_q, pend_we_d;

    logic          is_mul, is_div, is_madd, is_signed;
    logic [63:0]   a_ext, b_ext, product;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

    // Decode which issue class the current op belongs to
    always_comb begin
        is_mul    = (op == OP_MULT) || (op == OP_MULTU);
        is_div    = (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_madd   = (op == OP_MADD) || (op == OP_MADDU);
`else
        is_madd   = 1'b0;
`endif
        is_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    end

    // Full-width product and sign-magnitude division of the issue operands
    always_comb begin
        a_ext   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        product = a_ext * b_ext;
        // Magnitudes are unsigned, so 0x80000000 stays representable and
        // 0x80000000 / -1 naturally wraps back to 0x80000000.
        a_mag   = (is_signed && a[31]) ? (32'd0 - a) : a;
        b_mag   = (is_signed && b[31]) ? (32'd0 - b) : b;
        q_mag   = (b == 32'd0) ? 32'd0 : (a_mag / b_mag);
        r_mag   = (b == 32'd0) ? 32'd0 : (a_mag % b_mag);
        quot    = (is_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
        rem     = (is_signed && a[31]) ? (32'd0 - r_mag) : r_mag;
    end

    // Next state: count down and commit, or accept a new op when idle
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_we_d = pend_we_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1) && pend_we_q) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end else if (start) begin
            if (is_mul) begin
                pend_d    = product;
                pend_we_d = 1'b1;
                cnt_d     = MULT_LOAD;
            end else if (is_madd) begin
                // Accumulator base is HI/LO as seen at issue
                pend_d    = {hi_q, lo_q} + product;
                pend_we_d = 1'b1;
                cnt_d     = MULT_LOAD;
            end else if (is_div) begin
                // Divide by zero still occupies the unit but leaves HI/LO alone
                pend_d    = {rem, quot};
                pend_we_d = (b != 32'd0);
                cnt_d     = DIV_LOAD;
            end else if (op == OP_MTHI) begin
                hi_d = a;
            end else if (op == OP_MTLO) begin
                lo_d = a;
            end
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            cnt_q     <= '0;
            pend_q    <= 64'd0;
            pend_we_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign busy      = (cnt_q != '0);
    assign stall_req = busy | (start & (is_mul | is_div | is_madd));
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard bench for e_mdu with a reference model
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int op_len(input logic [3:0] o);
        case (o)
            4'd1, 4'd2: return MC;
            4'd3, 4'd4: return DC;
`ifdef MDU_MADD_EN
            4'd7, 4'd8: return MC;
`endif
            default:    return 0;
        endcase
    endfunction

    function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
    endfunction

    function automatic logic [63:0] umul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xx, yy;
        xx = {32'd0, x};
        yy = {32'd0, y};
        return xx * yy;
    endfunction

    // Architectural effect of one accepted op on the model HI/LO
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sa, sb, qq, rr;
        case (o)
            4'd1: {m_hi, m_lo} = smul(x, y);
            4'd2: {m_hi, m_lo} = umul(x, y);
            4'd3: if (y != 0) begin
                sa = longint'($signed(x));
                sb = longint'($signed(y));
                qq = sa / sb;
                rr = sa % sb;
                m_lo = qq[31:0];
                m_hi = rr[31:0];
            end
            4'd4: if (y != 0) begin
                m_lo = x / y;
                m_hi = x % y;
            end
            4'd5: m_hi = x;
            4'd6: m_lo = x;
`ifdef MDU_MADD_EN
            4'd7: {m_hi, m_lo} = {m_hi, m_lo} + smul(x, y);
            4'd8: {m_hi, m_lo} = {m_hi, m_lo} + umul(x, y);
`endif
            default: ;
        endcase
    endtask

    // Called one step after a rising edge with the unit idle
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        chk({name, " stall_req"}, {63'd0, stall_req}, {63'd0, op_len(o) != 0});
        @(posedge clk);
        model(o, x, y);
        e.hi = m_hi;
        e.lo = m_lo;
        e.len = op_len(o);
        e.name = name;
        q.push_back(e);
        #1;
        start = 1'b0;
        op    = 4'd0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            chk("drain", 64'(q.size()), 64'd0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the head expectation when the DUT presents a result
    initial begin
        int cnt;
        int idle;
        cnt = 0;
        idle = 0;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                cnt = 0;
                idle = 0;
            end else if (q[0].len == 0) begin
                chk({q[0].name, " hi"}, {32'd0, hi}, {32'd0, q[0].hi});
                chk({q[0].name, " lo"}, {32'd0, lo}, {32'd0, q[0].lo});
                chk({q[0].name, " busy"}, {63'd0, busy}, 64'd0);
                void'(q.pop_front());
            end else if (busy) begin
                cnt++;
                idle = 0;
                if (cnt > q[0].len + 4) begin
                    chk({q[0].name, " busy_len"}, 64'(cnt), 64'(q[0].len));
                    void'(q.pop_front());
                    cnt = 0;
                end
            end else if (cnt > 0) begin
                chk({q[0].name, " busy_len"}, 64'(cnt), 64'(q[0].len));
                chk({q[0].name, " hi"}, {32'd0, hi}, {32'd0, q[0].hi});
                chk({q[0].name, " lo"}, {32'd0, lo}, {32'd0, q[0].lo});
                void'(q.pop_front());
                cnt = 0;
            end else begin
                idle++;
                if (idle > 3) begin
                    chk({q[0].name, " busy_start"}, {63'd0, busy}, 64'd1);
                    void'(q.pop_front());
                    idle = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [3:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("reset stall_req", {63'd0, stall_req}, 64'd0);
        e.hi = 32'd0; e.lo = 32'd0; e.len = 0; e.name = "reset";
        q.push_back(e);
        wait_idle();

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, "mult");
        wait_idle();
        issue(4'd2, 32'hFFFF_FFFE, 32'd3, "multu");
        wait_idle();
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, "div");
        wait_idle();
        issue(4'd4, 32'd7, 32'd0, "divu_by0");
        wait_idle();
        issue(4'd5, 32'h1234_5678, 32'd0, "mthi");
        issue(4'd6, 32'h9ABC_DEF0, 32'd0, "mtlo");
        wait_idle();
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        wait_idle();

        // Starts during a busy window must be ignored entirely
        issue(4'd1, 32'h0001_0001, 32'h0000_0101, "mult_poked");
        start = 1'b1; op = 4'd5; a = 32'hDEAD_BEEF; b = 32'd0;
        #1;
        chk("poke stall_req", {63'd0, stall_req}, 64'd1);
        @(posedge clk);
        #1;
        op = 4'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'd0;
        wait_idle();

        // Reset during the third busy cycle of a DIV
        issue(4'd3, 32'd1000, 32'd7, "div_reset");
        q[q.size()-1].len = 3;
        q[q.size()-1].hi = 32'd0;
        q[q.size()-1].lo = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_idle();
        repeat (12) @(posedge clk);
        #1;
        issue(4'd0, 32'd0, 32'd0, "no_late_commit");
        wait_idle();

        issue(4'd5, 32'd0, 32'd0, "pre_hi");
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, "pre_lo");
        wait_idle();
        issue(4'd8, 32'd1, 32'd1, "maddu");
        wait_idle();
        issue(4'd7, 32'hFFFF_FFFF, 32'd5, "madd");
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            issue(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the Execute stage, next to the ALU.
- Takes forwarded operands from the ID/EX latch and holds the architectural HI/LO registers.
- For MFHI/MFLO, its hi/lo outputs feed the Execute result mux, which drives the EX/MEM register's result field.
- Asserts busy while an operation is in flight; the hazard unit stalls Decode on that.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (≥1).
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 clears state at the clock edge).
- start  input  1  issue strobe, qualified with op; one cycle per instruction.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD*, 8 MADDU* (*see Optional Feature); others = NONE.
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- busy  output  1  operation in flight.
- stall_req  output  1  combinational: busy | (start & op∈{1,2,3,4,7*,8*}).
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset==0 at edge):
  - hi=0, lo=0, busy=0, cycle counter=0.
  - Pending result discarded, including mid-operation.
  - Reset overrides start.
- Issue (start=1, busy=0, op MULT/MULTU/DIV/DIVU at edge k):
  - Compute 64-bit pending {hi,lo} from a, b.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- busy:
  - Counter decrements each edge while nonzero.
  - busy = (counter != 0), registered.
  - Therefore busy=1 after edge k through edge k+N−1, i.e. exactly N cycles.
- Commit:
  - On the edge where the counter goes 1→0 (edge k+N), hi/lo take the pending values.
  - New hi/lo and busy=0 are visible in the same cycle.
  - hi/lo stay unchanged while busy.
- Arithmetic:
  - MULT: signed 32×32→64; hi=upper, lo=lower.
  - MULTU: the same, unsigned.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder, sign of dividend.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b==0): counter still runs DIV_CYCLES; hi/lo unchanged at commit.
- MTHI/MTLO (start=1, busy=0): hi (resp. lo) ← a at that edge; no busy; the other register is untouched.
- start while busy=1: ignored entirely (no restart, no MTHI/MTLO write). Upstream must not issue this, since the hazard unit stalls.
- op NONE, or start=0: no state change.
- MFHI/MFLO are not handled here: Execute reads hi/lo combinationally; the hazard unit stalls them while stall_req=1.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 7 MADD: {hi,lo} ← {hi,lo} + signed(a)×signed(b), mod 2^64.
  - op 8 MADDU: the same, unsigned.
  - Both have MULT_CYCLES latency and are included in stall_req.
  - The accumulator base is {hi,lo} sampled at issue.
- Undefined: ops 7/8 decode as NONE; no state change; no stall_req.

Test Plan:
- Reset low for 2 cycles, then high → hi=0, lo=0, busy=0, stall_req=0.
- MULT, a=0xFFFFFFFE (−2), b=3 at edge k:
  - busy=1 for cycles k+1..k+5.
  - At k+5: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
  - Same operands with MULTU: hi=0x00000002, lo=0xFFFFFFFA.
- DIV, a=0xFFFFFFF9 (−7), b=2:
  - After 10 busy cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/0 afterwards: hi/lo unchanged after 10 busy cycles.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles:
  - Registers readable the next cycle.
  - busy stays 0.
  - start asserted during a MULT busy window: hi/lo and counter unaffected.
- reset=0 at the third busy cycle of a DIV → next cycle busy=0, hi=lo=0, no later commit.
- MDU_MADD_EN defined:
  - Preload hi=0, lo=0xFFFFFFFF via MTHI/MTLO.
  - MADDU a=1, b=1 → after 5 cycles hi=1, lo=0.
- MDU_MADD_EN undefined: the same op=8 → no busy, hi/lo unchanged.
